// File: rtl/key_conditioner.sv
// Push-button conditioner: two-flop synchroniser, edge debounce FSM and hold timer.
// Turns one active-low bouncing key into press/release pulses, a clean level and a hold flag.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 50_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_hold
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t state, state_next;

    logic sync1, sync2;
    logic key_s;

    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;
    logic level_next, press_next, release_next, hold_next;

    // Synchronisers idle in the released (high) state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    assign key_s = ~sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            hold_cnt    <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_hold    <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            hold_cnt    <= hold_cnt_next;
            key_level   <= level_next;
            key_press   <= press_next;
            key_release <= release_next;
            key_hold    <= hold_next;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        hold_cnt_next = hold_cnt;
        level_next    = key_level;
        press_next    = 1'b0;
        release_next  = 1'b0;
        hold_next     = key_hold;

        case (state)
            IDLE: begin
                if (key_s) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = CNT_ONE;
                end
            end

            PRESS_WAIT: begin
                if (!key_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_next    = PRESSED;
                    cnt_next      = '0;
                    level_next    = 1'b1;
                    press_next    = 1'b1;
                    hold_cnt_next = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end

            PRESSED: begin
                // Saturating hold timer; the flag is registered on the cycle the count lands.
                if (hold_cnt != HOLD_MAX) begin
                    hold_cnt_next = hold_cnt + HOLD_ONE;
                    if (hold_cnt_next == HOLD_MAX) begin
                        hold_next = 1'b1;
                    end
                end
                if (!key_s) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = CNT_ONE;
                end
            end

            RELEASE_WAIT: begin
                if (key_s) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_next   = IDLE;
                    cnt_next     = '0;
                    level_next   = 1'b0;
                    hold_next    = 1'b0;
                    release_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: stimulus queues expected output changes by edge number,
// a negedge monitor pops and compares every observed change of the four outputs.
module tb_key_conditioner;

    localparam int DEB  = 4;
    localparam int HOLD = 10;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    logic key_raw = 1'b1;
    logic key_level, key_press, key_release, key_hold;

    int edge_cnt    = 0;
    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int         cyc;
        logic [3:0] v;
    } ev_t;

    ev_t exp_q[$];

    key_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_raw    (key_raw),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_hold   (key_hold)
    );

    always #10 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Output vector order: {level, press, release, hold}
    function automatic logic [3:0] outs();
        return {key_level, key_press, key_release, key_hold};
    endfunction

    task automatic expect_ev(input int cyc, input logic [3:0] v);
        ev_t e;
        e.cyc = cyc;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    task automatic at_neg(input int e);
        while (edge_cnt < e) @(negedge clk);
    endtask

    // Value becomes visible to the DUT's first sampling flop at edge e.
    task automatic drive(input int e, input logic v);
        at_neg(e - 1);
        key_raw = v;
    endtask

    task automatic check_outs(input string name, input logic [3:0] want);
        vectors++;
        if (outs() !== want) begin
            miscompares++;
            $display("FAIL %s: edge %0d outputs %b, required %b", name, edge_cnt, outs(), want);
        end
    endtask

    initial begin : monitor
        logic [3:0] prev;
        logic [3:0] cur;
        ev_t        e;
        prev = 4'b0000;
        forever begin
            @(negedge clk);
            cur = outs();
            if (edge_cnt >= 1 && cur !== prev) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_change: edge %0d outputs %b, required no change from %b",
                             edge_cnt, cur, prev);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != edge_cnt || e.v !== cur) begin
                        miscompares++;
                        $display("FAIL output_change: edge %0d outputs %b, required edge %0d outputs %b",
                                 edge_cnt, cur, e.cyc, e.v);
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin : stimulus
        #1 reset_n = 1'b0;
        at_neg(1);
        check_outs("reset_state", 4'b0000);
        at_neg(2);
        reset_n = 1'b1;

        // Clean short press: press pulse 6 edges after first sample, no hold.
        expect_ev(16, 4'b1100);
        expect_ev(17, 4'b1000);
        expect_ev(26, 4'b0010);
        expect_ev(27, 4'b0000);
        drive(10, 1'b0);
        drive(20, 1'b1);

        // Press bounce, long hold, release bounce.
        expect_ev(50, 4'b1100);
        expect_ev(51, 4'b1000);
        expect_ev(60, 4'b1001);
        expect_ev(88, 4'b0010);
        expect_ev(89, 4'b0000);
        drive(40, 1'b0);
        drive(41, 1'b1);
        drive(42, 1'b0);
        drive(43, 1'b1);
        drive(44, 1'b0);
        at_neg(49);
        check_outs("no_press_during_bounce", 4'b0000);
        drive(80, 1'b1);
        drive(81, 1'b0);
        drive(82, 1'b1);

        // 3-sample release glitch while pressed: hold delayed by 3 frozen cycles.
        expect_ev(106, 4'b1100);
        expect_ev(107, 4'b1000);
        expect_ev(119, 4'b1001);
        drive(100, 1'b0);
        drive(110, 1'b1);
        drive(113, 1'b0);
        at_neg(118);
        check_outs("hold_frozen_by_glitch", 4'b1000);

        // Async reset mid-hold with key held, then normal press after deassertion.
        expect_ev(126, 4'b0000);
        expect_ev(134, 4'b1100);
        expect_ev(135, 4'b1000);
        expect_ev(144, 4'b1001);
        expect_ev(156, 4'b0010);
        expect_ev(157, 4'b0000);
        at_neg(125);
        check_outs("hold_before_reset", 4'b1001);
        #3 reset_n = 1'b0;
        #1 check_outs("async_reset_immediate", 4'b0000);
        at_neg(127);
        reset_n = 1'b1;
        drive(150, 1'b1);

        // Key released for 1000 cycles after a fresh reset: nothing moves.
        at_neg(160);
        reset_n = 1'b0;
        at_neg(162);
        reset_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            at_neg(162 + 100 * i);
            check_outs("idle_released", 4'b0000);
        end

        at_neg(1170);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_changes: %0d expected changes never seen, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
